// File: rtl/mdu_seq.sv
// mdu_seq: iterative RV32M multiply/divide sequencer sharing one 33-bit ripple adder.
// Build with MDU_DIV_EN defined to include the divider; without it divide ops finish at once flagged illegal.
module mdu_fa (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = x ^ y ^ ci;
    assign co = (x & y) | (ci & (x ^ y));
endmodule

module mdu_seq #(
    parameter int XLEN = 32,
    parameter int ITER = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic            illegal
);
`ifdef MDU_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif
    localparam int CW = $clog2(ITER);

    typedef enum logic [2:0] {IDLE, PREP_A, PREP_B, CALC, FIX_LO, FIX_HI, DONE} state_t;

    state_t          state, nstate;
    logic [2:0]      op_q;
    logic [XLEN-1:0] hi, lo, dv;
    logic            sa, neg_res, fix_c, ill_q;
    logic [CW-1:0]   cnt;
    logic [XLEN:0]   ax, ay, sum;
    logic [XLEN+1:0] ch;
    logic            cin, div_op, is_rem, sgn_a, sgn_b, ill_start;

    assign div_op    = DIV_EN && op_q[2];
    assign is_rem    = op_q[1];
    assign sgn_a     = (op_q == 3'b001) || (op_q == 3'b010) || (op_q == 3'b100) || (op_q == 3'b110);
    assign sgn_b     = (op_q == 3'b001) || (op_q == 3'b100) || (op_q == 3'b110);
    assign ill_start = !DIV_EN && op[2];

    assign ch[0] = cin;
    for (genvar i = 0; i <= XLEN; i++) begin : g_fa
        mdu_fa u_fa (.x(ax[i]), .y(ay[i]), .ci(ch[i]), .s(sum[i]), .co(ch[i+1]));
    end

    // Single adder, operands steered by state; divide subtracts via ~dvsr + 1.
    always_comb begin
        ax  = '0;
        ay  = '0;
        cin = 1'b0;
        case (state)
            PREP_A: begin
                ax  = {1'b0, ~lo};
                cin = 1'b1;
            end
            PREP_B: begin
                ax  = {1'b0, ~dv};
                cin = 1'b1;
            end
            CALC: begin
                ax  = div_op ? {hi, lo[XLEN-1]} : {1'b0, hi};
                ay  = div_op ? {1'b1, ~dv} : {1'b0, dv};
                cin = div_op;
            end
            FIX_LO: begin
                ax  = {1'b0, ~((div_op && is_rem) ? hi : lo)};
                cin = 1'b1;
            end
            FIX_HI: begin
                ax  = {1'b0, ~hi};
                cin = fix_c;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else state <= nstate;
    end

    always_comb begin
        nstate = state;
        if (flush) nstate = IDLE;
        else begin
            case (state)
                IDLE:    nstate = start ? (ill_start ? DONE : PREP_A) : IDLE;
                PREP_A:  nstate = PREP_B;
                PREP_B:  nstate = CALC;
                CALC:    nstate = (cnt == CW'(ITER - 1)) ? FIX_LO : CALC;
                FIX_LO:  nstate = FIX_HI;
                FIX_HI:  nstate = DONE;
                default: nstate = IDLE;
            endcase
        end
    end

    always_comb begin
        busy    = state != IDLE;
        done    = (state == DONE) && !flush;
        illegal = done && ill_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result  <= '0;
            cnt     <= '0;
            op_q    <= '0;
            hi      <= '0;
            lo      <= '0;
            dv      <= '0;
            sa      <= 1'b0;
            neg_res <= 1'b0;
            fix_c   <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            cnt <= (state == CALC) ? cnt + 1'b1 : '0;
            case (state)
                IDLE: if (start && !flush) begin
                    op_q  <= op;
                    lo    <= a;
                    dv    <= b;
                    hi    <= '0;
                    ill_q <= ill_start;
                    if (ill_start) result <= '0;
                end
                PREP_A: begin
                    sa <= sgn_a && lo[XLEN-1];
                    if (sgn_a && lo[XLEN-1]) lo <= sum[XLEN-1:0];
                end
                PREP_B: begin
                    if (sgn_b && dv[XLEN-1]) dv <= sum[XLEN-1:0];
                    // A zero divisor keeps the all-ones quotient un-negated.
                    neg_res <= (op_q == 3'b110) ? sa :
                               ((op_q == 3'b001) || (op_q == 3'b010) || ((op_q == 3'b100) && (dv != '0))) ?
                               sa ^ (sgn_b && dv[XLEN-1]) : 1'b0;
                end
                CALC: begin
                    if (div_op) begin
                        hi <= ch[XLEN+1] ? sum[XLEN-1:0] : {hi[XLEN-2:0], lo[XLEN-1]};
                        lo <= {lo[XLEN-2:0], ch[XLEN+1]};
                    end else begin
                        {hi, lo} <= {(lo[0] ? sum : {1'b0, hi}), lo[XLEN-1:1]};
                    end
                end
                FIX_LO: begin
                    fix_c <= sum[XLEN];
                    lo    <= neg_res ? sum[XLEN-1:0] : ((div_op && is_rem) ? hi : lo);
                end
                FIX_HI: if (!flush) begin
                    result <= (div_op || op_q[1:0] == 2'b00) ? lo : (neg_res ? sum[XLEN-1:0] : hi);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mdu_seq.sv
// tb_mdu_seq: table vectors, corner sequences and random ops checked against an arithmetic model of RV32M.
module tb_mdu_seq;
`ifdef MDU_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, flush = 1'b0;
    logic [2:0]  op = '0;
    logic [31:0] a = '0, b = '0;
    logic        busy, done, illegal;
    logic [31:0] result;
    int          n_chk = 0, n_fail = 0;

    mdu_seq dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b), .flush(flush),
        .busy(busy), .done(done), .result(result), .illegal(illegal)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] sx, sy, ux, uy, p;
        logic        ovf;
        sx  = {{32{x[31]}}, x};
        sy  = {{32{y[31]}}, y};
        ux  = {32'b0, x};
        uy  = {32'b0, y};
        ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
        if (!DIV_EN && o[2]) return 32'h0;
        case (o)
            3'd0: begin p = ux * uy; return p[31:0]; end
            3'd1: begin p = sx * sy; return p[63:32]; end
            3'd2: begin p = sx * uy; return p[63:32]; end
            3'd3: begin p = ux * uy; return p[63:32]; end
            3'd4: return (y == 0) ? 32'hFFFF_FFFF : ovf ? x : 32'($signed(x) / $signed(y));
            3'd5: return (y == 0) ? 32'hFFFF_FFFF : x / y;
            3'd6: return (y == 0) ? x : ovf ? 32'h0 : 32'($signed(x) % $signed(y));
            default: return (y == 0) ? x : x % y;
        endcase
    endfunction

    task automatic run_chk(input string name, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                           input logic [31:0] ex);
        int          lat, exp_lat;
        logic [31:0] r;
        logic        il, ill;
        lat     = 0;
        r       = '0;
        il      = 1'b0;
        ill     = !DIV_EN && o[2];
        exp_lat = ill ? 1 : 37;
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; a = $urandom; b = $urandom;
        chk({name, " busy@1"}, 32'(busy), 32'd1);
        for (int k = 1; k <= 60 && lat == 0; k++) begin
            if (k > 1) @(negedge clk);
            if (done) begin
                lat = k;
                r   = result;
                il  = illegal;
            end
        end
        chk({name, " latency"}, lat, exp_lat);
        chk({name, " result"}, r, ex);
        chk({name, " illegal"}, 32'(il), 32'(ill));
        @(negedge clk);
        chk({name, " busy after"}, 32'(busy), 32'd0);
        chk({name, " done pulse"}, 32'(done), 32'd0);
        chk({name, " held"}, result, ex);
    endtask

    initial begin
        vec_t        vecs[15];
        int          lat;
        logic [31:0] r, x, y;
        logic [2:0]  o;
        logic        seen;

        vecs[0]  = '{3'b000, 32'd7,         32'd6,         32'h0000_002A};
        vecs[1]  = '{3'b001, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF};
        vecs[2]  = '{3'b011, 32'hFFFF_FFFF, 32'd2,         32'h0000_0001};
        vecs[3]  = '{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        vecs[4]  = '{3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001};
        vecs[5]  = '{3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
        vecs[6]  = '{3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD};
        vecs[7]  = '{3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF};
        vecs[8]  = '{3'b101, 32'h1234_5678, 32'd0,         32'hFFFF_FFFF};
        vecs[9]  = '{3'b110, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9};
        vecs[10] = '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
        vecs[11] = '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000};
        vecs[12] = '{3'b100, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF};
        vecs[13] = '{3'b111, 32'd7,         32'd0,         32'd7};
        vecs[14] = '{3'b000, 32'd3,         32'd5,         32'h0000_000F};

        repeat (3) @(negedge clk);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset illegal", 32'(illegal), 32'd0);
        chk("reset result", result, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vecs[i])
            run_chk($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                    (!DIV_EN && vecs[i].op[2]) ? 32'h0 : vecs[i].exp);

        run_chk("div then", 3'b100, 32'd20, 32'd3, DIV_EN ? 32'd6 : 32'd0);
        run_chk("mul 3x5", 3'b000, 32'd3, 32'd5, 32'h0000_000F);

        // A second start during the operation must be ignored.
        op = 3'b000; a = 32'd3; b = 32'd5; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        op = 3'b011; a = 32'hFFFF_FFFF; b = 32'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        r = '0;
        for (int k = 7; k <= 60 && lat == 0; k++) begin
            @(negedge clk);
            if (done) begin
                lat = k;
                r   = result;
            end
        end
        chk("busy start latency", lat, 37);
        chk("busy start result", r, 32'h0000_000F);
        @(negedge clk);
        chk("busy start idle", 32'(busy), 32'd0);

        // Flush at T+10 aborts without done and keeps the previous result.
        op = DIV_EN ? 3'b101 : 3'b011; a = 32'd100; b = 32'd7; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        seen = done;
        for (int k = 2; k <= 10; k++) begin
            @(negedge clk);
            seen = seen | done;
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        seen = seen | done;
        chk("flush busy", 32'(busy), 32'd0);
        chk("flush no done", 32'(seen), 32'd0);
        chk("flush result", result, 32'h0000_000F);
        run_chk("after flush", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);

        // Reset mid-operation aborts and clears the result.
        op = 3'b000; a = 32'd9; b = 32'd9; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midreset busy", 32'(busy), 32'd0);
        chk("midreset result", result, 32'd0);
        seen = 1'b0;
        repeat (45) begin
            @(negedge clk);
            seen = seen | done;
        end
        chk("midreset no done", 32'(seen), 32'd0);

        for (int n = 0; n < 150; n++) begin
            o = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 5))
                0: x = 32'h0;
                1: x = 32'h8000_0000;
                2: x = 32'hFFFF_FFFF;
                default: x = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0: y = 32'h0;
                1: y = 32'h8000_0000;
                2: y = 32'hFFFF_FFFF;
                default: y = $urandom;
            endcase
            run_chk($sformatf("rand%0d op%0d a=%h b=%h", n, o, x, y), o, x, y, model(o, x, y));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
